counter_mod: RTL

//  Parametrised modulo counter: up/down, runtime limit, continuous or one-shot mode.
//  Run-control FSM with start/stop commands; registered wrap pulse.

---
 rtl/counter_mod_pkg.sv | 14 +
 rtl/counter_mod_step.sv | 39 +++
 rtl/counter_mod.sv | 107 ++++++++++
 3 files changed

// File: rtl/counter_mod_pkg.sv
// Shared types and constants for the modulo counter.
package counter_mod_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } counter_mod_state_t;

  // Adder structure used for the step logic
  localparam int IMPL_CARRY = 0;
  localparam int IMPL_MUX   = 1;

endpackage

// File: rtl/counter_mod_step.sv
// Combinational next-count and terminal-tick detection for counter_mod.
// With IMPLEMENTATION=IMPL_CARRY the tick feeds the adder carry-in; with IMPL_MUX
// a +/-1 result is selected by the tick. Both give identical results.
module counter_mod_step
  import counter_mod_pkg::*;
#(
  parameter int unsigned WIDTH          = 16,
  parameter int          IMPLEMENTATION = 0
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] lim_q,
  input  logic             dir_q,
  input  logic             tick,
  output logic [WIDTH-1:0] nxt,
  output logic             term
);

  // Terminal tick: a tick taken while sitting on the end of the range
  assign term = tick & (dir_q ? (cnt == '0) : (cnt == lim_q));

  generate
    case (IMPLEMENTATION)
      IMPL_CARRY: begin : g_carry
        logic [WIDTH-1:0] inc;
        assign inc = WIDTH'(tick);
        assign nxt = dir_q ? (cnt - inc) : (cnt + inc);
      end
      IMPL_MUX: begin : g_mux
        logic [WIDTH-1:0] stepped;
        assign stepped = dir_q ? (cnt - WIDTH'(1)) : (cnt + WIDTH'(1));
        assign nxt     = tick ? stepped : cnt;
      end
      default: begin : g_bad
        $fatal(1, "counter_mod_step: IMPLEMENTATION must be 0 or 1");
      end
    endcase
  endgenerate

endmodule

// File: rtl/counter_mod.sv
// Parametrised modulo counter with run-control FSM (IDLE/RUN/DONE).
// Up/down, runtime limit, continuous or one-shot, registered wrap pulse.
// Optional sticky wrap flag 'ovf' when COUNTER_MOD_OVF_EN is defined.
module counter_mod
  import counter_mod_pkg::*;
#(
  parameter int unsigned WIDTH          = 16,
  parameter int          IMPLEMENTATION = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             ena,
  input  logic             dir,
  input  logic             one,
  input  logic [WIDTH-1:0] lim,
  output logic [WIDTH-1:0] cnt,
`ifdef COUNTER_MOD_OVF_EN
  output logic             ovf,
`endif
  output logic             wrap,
  output logic             run,
  output logic             done
);

  counter_mod_state_t state_q;
  logic [WIDTH-1:0]   cnt_q;
  logic [WIDTH-1:0]   lim_q;
  logic               dir_q;
  logic               one_q;
  logic               wrap_q;
  logic               tick;
  logic               term;
  logic [WIDTH-1:0]   nxt;

  assign tick = ena & (state_q == RUN);

  counter_mod_step #(
    .WIDTH          (WIDTH),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_step (
    .cnt   (cnt_q),
    .lim_q (lim_q),
    .dir_q (dir_q),
    .tick  (tick),
    .nxt   (nxt),
    .term  (term)
  );

  // Run-control FSM, count register and shadow registers; stop > start > tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lim_q   <= '0;
      dir_q   <= 1'b0;
      one_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (stop) begin
        state_q <= IDLE;
      end else if (start) begin
        state_q <= RUN;
        lim_q   <= lim;
        dir_q   <= dir;
        one_q   <= one;
        cnt_q   <= dir ? lim : '0;
      end else if (term) begin
        wrap_q <= 1'b1;
        if (one_q) begin
          state_q <= DONE;
        end else begin
          // New limit is only adopted at the wrap point
          cnt_q <= dir_q ? lim : '0;
          lim_q <= lim;
        end
      end else begin
        cnt_q <= nxt;
      end
    end
  end

`ifdef COUNTER_MOD_OVF_EN
  logic ovf_q;

  // Sticky wrap flag; start/stop clear it and win over a same-cycle wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (stop || start) begin
      ovf_q <= 1'b0;
    end else if (term) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`endif

  assign cnt  = cnt_q;
  assign wrap = wrap_q;
  assign run  = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule
